// File: rtl/ram_defs.sv
// Shared definitions for the simple-dual-port RAM and its clear sequencer.
package ram_defs;

    // Clear sequencer states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-address read-during-write policies
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then reports ready.
module ram_clear_seq
    import ram_defs::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    // State register and clear address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end
    end

    // Next state: leave CLEAR on the edge that writes the all-ones address
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Outputs: busy and clear write strobe for the whole CLEAR state
    always_comb begin
        busy     = (state == ST_CLEAR);
        clr_we   = (state == ST_CLEAR);
        clr_addr = clr_cnt;
    end

endmodule

// File: rtl/sync_ram_sdp.sv
// Single-clock simple-dual-port RAM with registered read, selectable read
// latency, read-valid strobe, read-during-write policy and post-reset clear.
module sync_ram_sdp
    import ram_defs::*;
#(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 4,
    parameter int                READ_LAT = 1,
    parameter int                RDW_MODE = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rd_go;
    logic              bypass;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write port mux: the clear sequencer owns the array while busy
    always_comb begin
        mem_we   = wr_en && !rst;
        mem_addr = wr_addr;
        mem_data = wr_data;
        if (clr_we) begin
            mem_we   = !rst;
            mem_addr = clr_addr;
            mem_data = CLR_VAL;
        end
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Read acceptance and same-address write-first bypass
    always_comb begin
        rd_go  = rd_en && !busy;
        bypass = (RDW_MODE == RDW_WRITE_FIRST) && wr_en && (wr_addr == rd_addr);
    end

    // First read stage: array read (old data unless bypassed)
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= bypass ? wr_data : mem[rd_addr];
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            // Single stage drives the outputs directly
            always_comb begin
                rd_data  = s1_data;
                rd_valid = s1_valid;
            end
        end else if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            // Second output register, free-running, holds data between results
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            // Outputs from second stage
            always_comb begin
                rd_data  = s2_data;
                rd_valid = s2_valid;
            end
        end else begin : g_bad_lat
            $error("sync_ram_sdp: READ_LAT must be 1 or 2");
        end
    endgenerate

endmodule

// File: doc/sync_ram_sdp.md
Name: sync_ram_sdp

Overview:
- Parametrised single-clock simple-dual-port RAM: one write port and one read port.
- Successor to the fixed 16x4 combinational ROM. Adds writes, registered read with configurable latency, a read-valid strobe, a read-during-write policy and a hardware clear sequencer after reset.
- Sits as the generic storage primitive for lab designs (lookup tables, scratch buffers, FIFO backing store).

Parameters:
DATA_W, 4, data word width in bits (1..64)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
READ_LAT, 1, read latency in clock edges; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)
CLR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active high
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  1  read strobe
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data, registered
rd_valid  output  1  one-cycle pulse marking rd_data as a fresh read result
busy  output  1  high while the clear sequencer runs; port requests are ignored

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= CLEAR, clear counter <= 0.
  - rd_data <= 0, rd_valid <= 0, busy <= 1.
  - Read pipeline flushed; memory contents are not touched by reset itself.
- FSM states: CLEAR, READY.
- CLEAR, each edge with rst=0:
  - mem[clr_cnt] <= CLR_VAL, then clr_cnt increments.
  - On the edge that writes address DEPTH-1: state <= READY, busy <= 0.
  - Sequence: rst released, edges E1..E_DEPTH write addresses 0..DEPTH-1, busy low after E_DEPTH.
  - wr_en and rd_en are ignored; rd_valid stays 0.
- Reset during CLEAR restarts the clear from address 0. Reset during READY flushes in-flight reads (no rd_valid is emitted for them) and re-runs the clear.
- READY write: wr_en=1 at edge T stores wr_data at mem[wr_addr] at T.
- READY read:
  - rd_en=1 at edge T means rd_data/rd_valid are updated at edge T+READ_LAT-1 (visible after edge T when READ_LAT=1, after edge T+1 when READ_LAT=2).
  - READ_LAT=2 adds one output register stage. Both stages advance every cycle (no stall).
  - Back-to-back reads give one result per cycle.
- rd_valid is high for exactly one cycle per accepted read. rd_data holds its last value when no read completes.
- Read-during-write, wr_en and rd_en in the same edge:
  - Same address, RDW_MODE=0: read returns the pre-write word.
  - Same address, RDW_MODE=1: read returns wr_data (bypass).
  - Different addresses: independent.
- Two writes to the same address on consecutive edges: last one wins.
- Addresses are ADDR_W bits wide, so there is no out-of-range case. The clear counter is ADDR_W+1 bits or uses terminal detect at all-ones; it must not wrap back into CLEAR.
- Illegal READ_LAT (not 1 or 2): elaboration-time error via a generate-block guard.
- Memory is inferred as a reg array. No combinational path exists from any input to rd_data.

Decomposition:
- Shared package/include file `ram_defs`:
  - state encoding constants ST_CLEAR=1'b0, ST_READY=1'b1
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1
- One natural sub-module, `ram_clear_seq`: the counter plus FSM that produces busy, the clear address and the clear write-enable. The top module muxes these onto the write port ahead of the array.
- Read pipeline and bypass logic stay in the top module.

Test Plan:
1. Clear after reset, defaults: pulse rst 1 cycle, count edges -> busy high for exactly 16 edges then 0. Reading all addresses 0..15 returns 4'h0 with rd_valid on the edge after each rd_en.
2. Write/read with READ_LAT=1: write addr 2=4'h5, 3=4'h9, A=4'hC, F=4'h3; read 2,3,A,F back-to-back -> rd_data 5,9,C,3 on consecutive cycles, rd_valid high 4 cycles then low, rd_data holds 4'h3.
3. Latency 2, DATA_W=8, ADDR_W=6: rd_en at edge T for addr 6'h21 holding 8'hA5 -> rd_valid and rd_data=8'hA5 after edge T+1, not after T. The clear phase lasts 64 edges.
4. Read-during-write: addr 4'hB holds 4'h1; same edge write 4'h7 and read 4'hB -> RDW_MODE=0 returns 4'h1, RDW_MODE=1 returns 4'h7. A following read returns 4'h7 in both modes.
5. Reset mid-operation: assert rst during clear at clr_cnt=5 -> busy stays high and the clear restarts, giving 16 more edges. Assert rst with a read in flight (READ_LAT=2) -> no rd_valid pulse, rd_data=0.
6. Requests during busy: drive wr_en addr 1 data 4'hF and rd_en throughout CLEAR -> no rd_valid, and after busy falls addr 1 reads 4'h0 (CLR_VAL). With CLR_VAL=4'hE, all words read 4'hE.
